bit_serial_subtractor: RTL and testbench

- Multi-cycle, area-minimal subtractor; the inverse operation of the team's combinational ripple-carry adder.
- Computes diff = a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Used in the arithmetic datapath where latency is tolerable and gate count matters.
- Start/done handshake toward the controlling sequencer.

---
 rtl/bit_serial_subtractor.sv | 92 +++++++++
 tb/tb_bit_serial_subtractor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// built from a single full-subtractor cell and a borrow flop.
module bit_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic w_ai, w_bi, w_d, w_br_next, w_last;

  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_br;
  assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_br  <= bin;
          r_cnt <= '0;
          busy  <= 1'b1;
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          // On the final bit the operand LSBs are the captured sign bits.
          if (w_last) begin
            diff <= {w_d, r_res[WIDTH-1:1]};
            bout <= w_br_next;
            ovf  <= (w_ai ^ w_bi) & (w_d ^ w_ai);
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        S_DONE:  done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: directed vectors, random
// operands against an arithmetic reference, handshake and reset scenarios.
module tb_bit_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  bit_serial_subtractor #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, bout, diff} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rbin);
    logic [W:0] r;
    logic       o;
    r = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
    o = (ra[W-1] != rb[W-1]) && (r[W-1] != ra[W-1]);
    return {o, r[W], r[W-1:0]};
  endfunction

  // Drive an accepted start; returns #1 after the accepting edge with the
  // inputs scrambled so capture is exercised.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Cycles from acceptance until done is seen (-1 on timeout); then one more
  // edge so the block is back in IDLE.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin cyc = k; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int busy_cnt = 0;
    int done_at  = -1;
    if (busy) busy_cnt++;
    launch(8'h05, 8'h03, 1'b0);
    if (busy) busy_cnt++;
    for (int k = 1; k <= W + 2; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = k;
    end
    checks++;
    if (done_at != W) begin
      errors++; $display("FAIL basic_latency: got %0d, want %0d", done_at, W);
    end
    checks++;
    if (busy_cnt != W) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d, want %0d", busy_cnt, W);
    end
    checks++;
    if ({diff, bout, ovf} !== {8'h02, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_result: got diff=%h bout=%b ovf=%b, want 02 0 0", diff, bout, ovf);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{8'h00, 8'h80, 8'h7F, 8'h10, 8'h00, 8'hFF};
    logic [W-1:0] vb [6] = '{8'h01, 8'h01, 8'hFF, 8'h0F, 8'h00, 8'hFF};
    logic         vc [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [W+1:0] exp;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      launch(va[i], vb[i], vc[i]);
      wait_done(cyc);
      exp = ref_sub(va[i], vb[i], vc[i]);
      checks++;
      if (cyc != W) begin
        errors++; $display("FAIL directed%0d_latency: got %0d, want %0d", i, cyc, W);
      end
      checks++;
      if ({ovf, bout, diff} !== exp) begin
        errors++;
        $display("FAIL directed%0d_result: a=%h b=%h bin=%b got ovf=%b bout=%b diff=%h, want ovf=%b bout=%b diff=%h",
                 i, va[i], vb[i], vc[i], ovf, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W+1:0] exp;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      launch(ra, rb, rc);
      wait_done(cyc);
      exp = ref_sub(ra, rb, rc);
      checks++;
      if (cyc != W || {ovf, bout, diff} !== exp) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h bin=%b cyc=%0d got ovf=%b bout=%b diff=%h, want cyc=%0d ovf=%b bout=%b diff=%h",
                 i, ra, rb, rc, cyc, ovf, bout, diff, W, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_start_during_run();
    int dones = 0;
    logic [W+1:0] exp;
    exp = ref_sub(8'h9C, 8'h21, 1'b0);
    launch(8'h9C, 8'h21, 1'b0);
    for (int k = 1; k <= W + 8; k++) begin
      if (k == 3) begin a = 8'h11; b = 8'h77; bin = 1'b1; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL ignore_start_dones: got %0d, want 1", dones);
    end
    checks++;
    if ({ovf, bout, diff} !== exp) begin
      errors++;
      $display("FAIL ignore_start_result: got ovf=%b bout=%b diff=%h, want ovf=%b bout=%b diff=%h",
               ovf, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int last_done = -1;
    int pulses    = 0;
    int bad_gap   = 0;
    int unstable  = 0;
    logic [W-1:0] prev;
    logic [W+1:0] exp;
    exp = ref_sub(8'h3C, 8'h5A, 1'b0);
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; bin = 1'b0; start = 1'b1;
    prev = diff;
    for (int k = 1; k <= 60 && pulses < 4; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (last_done >= 0 && k - last_done != W + 2) bad_gap++;
        last_done = k;
        pulses++;
        if (pulses == 4) start = 1'b0;
      end else if (diff !== prev) unstable++;
      prev = diff;
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pulses != 4 || bad_gap != 0) begin
      errors++; $display("FAIL b2b_period: pulses=%0d bad_gaps=%0d, want 4 and 0", pulses, bad_gap);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL b2b_diff_stable: got %0d changes outside done, want 0", unstable);
    end
    checks++;
    if ({ovf, bout, diff} !== exp) begin
      errors++;
      $display("FAIL b2b_result: got ovf=%b bout=%b diff=%h, want ovf=%b bout=%b diff=%h",
               ovf, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones = 0;
    int cyc;
    launch(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL midrst_no_done: got %0d active cycles, want 0", dones);
    end
    launch(8'hAA, 8'h55, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc != W || diff !== 8'h55 || bout !== 1'b0) begin
      errors++; $display("FAIL midrst_fresh: cyc=%0d diff=%h bout=%b, want %0d 55 0", cyc, diff, bout, W);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
